// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: shared definitions for the E-stage multiply/divide unit.
// Holds the MDUOp code set that the control decode produces and the stall unit
// inspects, the unit's FSM state type, and the default operation latencies.
package e_mdu_pkg;

    // Operation codes carried on MDUOp; any code not listed here behaves as NONE.
    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MADD  = 4'd7,
        MDU_MADDU = 4'd8,
        MDU_MSUB  = 4'd9,
        MDU_MSUBU = 4'd10
    } mdu_op_e;

    // IDLE: no operation in flight. RUN: result parked in the shadow registers.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // A HI/LO pair; packing hi above lo makes {HI,LO} a plain 64-bit value.
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    // Default busy lengths and the width of the down-counter (latencies 1..15).
    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;
    localparam int MDU_CNT_W           = 4;

endpackage

// File: rtl/e_mdu.sv
// e_mdu: multiply/divide unit of the E stage.
// The full 64-bit result is computed at the launch edge into shadow registers;
// a down-counter then models the operation latency, and HI/LO are updated from
// the shadow only when the counter expires, so partial results are never seen.
// MTHI/MTLO write HI/LO directly with zero latency.
// Optional build macro MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (accumulate
// into {HI,LO}); without it those codes behave as NONE.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        active,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [MDU_CNT_W-1:0] LP_MULT_CNT = MDU_CNT_W'(MULT_CYCLES);
    localparam logic [MDU_CNT_W-1:0] LP_DIV_CNT  = MDU_CNT_W'(DIV_CYCLES);

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder takes the dividend's sign. 0x80000000 / -1 naturally yields
    // quotient 0x80000000 and remainder 0 without an overflow special case.
    function automatic hilo_t div_signed(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] q;
        logic [31:0] r;
        hilo_t       res;
        mag_a = a[31] ? (32'd0 - a) : a;
        mag_b = b[31] ? (32'd0 - b) : b;
        if (mag_b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = mag_a / mag_b;
            r = mag_a % mag_b;
        end
        res.lo = (a[31] ^ b[31]) ? (32'd0 - q) : q;
        res.hi = a[31] ? (32'd0 - r) : r;
        return res;
    endfunction

    // Unsigned divide: quotient in lo, remainder in hi.
    function automatic hilo_t div_unsigned(input logic [31:0] a, input logic [31:0] b);
        hilo_t res;
        if (b == 32'd0) begin
            res = '0;
        end else begin
            res.lo = a / b;
            res.hi = a % b;
        end
        return res;
    endfunction

    mdu_state_e             r_state;
    mdu_state_e             w_state_n;
    logic [MDU_CNT_W-1:0]   r_cnt;
    logic [MDU_CNT_W-1:0]   w_cnt_n;
    hilo_t                  r_shadow;
    hilo_t                  w_shadow_n;
    hilo_t                  r_hilo;
    hilo_t                  w_hilo_n;

    logic signed [63:0]     w_a_s;
    logic signed [63:0]     w_b_s;
    logic signed [63:0]     w_prod_s;
    logic [63:0]            w_prod_s_bits;
    logic [63:0]            w_prod_u;
    hilo_t                  w_div_s;
    hilo_t                  w_div_u;
    logic                   w_b_zero;

    assign w_a_s         = {{32{A[31]}}, A};
    assign w_b_s         = {{32{B[31]}}, B};
    assign w_prod_s      = w_a_s * w_b_s;
    assign w_prod_s_bits = w_prod_s;
    assign w_prod_u      = {32'd0, A} * {32'd0, B};
    assign w_div_s       = div_signed(A, B);
    assign w_div_u       = div_unsigned(A, B);
    assign w_b_zero      = (B == 32'd0);

`ifdef MDU_MADD_EN
    logic [63:0] w_acc;
    logic [63:0] w_madd;
    logic [63:0] w_maddu;
    logic [63:0] w_msub;
    logic [63:0] w_msubu;

    // Accumulator is the architectural {HI,LO} at the launch edge.
    assign w_acc   = r_hilo;
    assign w_madd  = w_acc + w_prod_s_bits;
    assign w_maddu = w_acc + w_prod_u;
    assign w_msub  = w_acc - w_prod_s_bits;
    assign w_msubu = w_acc - w_prod_u;
`endif

    // State, counter, shadow and HI/LO registers; reset aborts any pending op.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_hilo   <= '0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_shadow <= w_shadow_n;
            r_hilo   <= w_hilo_n;
        end
    end

    // Launch decode in IDLE, latency countdown and commit in RUN.
    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_shadow_n = r_shadow;
        w_hilo_n   = r_hilo;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    case (MDUOp)
                        MDU_MULT: begin
                            w_shadow_n = w_prod_s_bits;
                            w_cnt_n    = LP_MULT_CNT;
                            w_state_n  = ST_RUN;
                        end
                        MDU_MULTU: begin
                            w_shadow_n = w_prod_u;
                            w_cnt_n    = LP_MULT_CNT;
                            w_state_n  = ST_RUN;
                        end
                        MDU_DIV: begin
                            // Divide by zero still occupies the unit but
                            // commits the current HI/LO back unchanged.
                            w_shadow_n = w_b_zero ? r_hilo : w_div_s;
                            w_cnt_n    = LP_DIV_CNT;
                            w_state_n  = ST_RUN;
                        end
                        MDU_DIVU: begin
                            w_shadow_n = w_b_zero ? r_hilo : w_div_u;
                            w_cnt_n    = LP_DIV_CNT;
                            w_state_n  = ST_RUN;
                        end
                        MDU_MTHI: begin
                            w_hilo_n.hi = A;
                        end
                        MDU_MTLO: begin
                            w_hilo_n.lo = A;
                        end
`ifdef MDU_MADD_EN
                        MDU_MADD: begin
                            w_shadow_n = w_madd;
                            w_cnt_n    = LP_MULT_CNT;
                            w_state_n  = ST_RUN;
                        end
                        MDU_MADDU: begin
                            w_shadow_n = w_maddu;
                            w_cnt_n    = LP_MULT_CNT;
                            w_state_n  = ST_RUN;
                        end
                        MDU_MSUB: begin
                            w_shadow_n = w_msub;
                            w_cnt_n    = LP_MULT_CNT;
                            w_state_n  = ST_RUN;
                        end
                        MDU_MSUBU: begin
                            w_shadow_n = w_msubu;
                            w_cnt_n    = LP_MULT_CNT;
                            w_state_n  = ST_RUN;
                        end
`endif
                        default: begin
                        end
                    endcase
                end
            end
            ST_RUN: begin
                // start is ignored here; the stall unit keeps it low anyway.
                w_cnt_n = r_cnt - 1'b1;
                if (r_cnt == {{(MDU_CNT_W-1){1'b0}}, 1'b1}) begin
                    w_hilo_n  = r_shadow;
                    w_state_n = ST_IDLE;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    assign busy   = (r_state == ST_RUN);
    assign active = start | busy;
    assign HI     = r_hilo.hi;
    assign LO     = r_hilo.lo;

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: self-checking bench for e_mdu. Table-driven directed vectors,
// hand-written reset-abort and start-while-busy sequences, then randomized
// operations checked against a 64-bit arithmetic reference model.
module tb_e_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        active;
    logic [31:0] HI;
    logic [31:0] LO;

    always #5 clk = ~clk;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .MDUOp  (MDUOp),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .active (active),
        .HI     (HI),
        .LO     (LO)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(string name, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                    logic [31:0] pre_hi, logic [31:0] pre_lo,
                                    logic [31:0] exp_hi, logic [31:0] exp_lo, int exp_lat);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b;
        v.pre_hi = pre_hi; v.pre_lo = pre_lo;
        v.exp_hi = exp_hi; v.exp_lo = exp_lo; v.exp_lat = exp_lat;
        vecs.push_back(v);
    endfunction

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        else
            n_pass++;
    endfunction

    // Reference model: architectural effect of one launched op on {HI,LO}.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [63:0] acc_in, output logic [63:0] acc_out,
                                  output int lat);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          sq;
        longint          sr;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        acc_out = acc_in;
        lat = 0;
        case (op)
            4'd1: begin acc_out = sa * sb; lat = MC; end
            4'd2: begin acc_out = ua * ub; lat = MC; end
            4'd3: begin
                lat = DC;
                if (b != 0) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    acc_out = {sr[31:0], sq[31:0]};
                end
            end
            4'd4: begin
                lat = DC;
                if (b != 0) acc_out = {32'(ua % ub), 32'(ua / ub)};
            end
            4'd5: acc_out = {a, acc_in[31:0]};
            4'd6: acc_out = {acc_in[63:32], a};
`ifdef MDU_MADD_EN
            4'd7:  begin acc_out = acc_in + 64'(sa * sb); lat = MC; end
            4'd8:  begin acc_out = acc_in + 64'(ua * ub); lat = MC; end
            4'd9:  begin acc_out = acc_in - 64'(sa * sb); lat = MC; end
            4'd10: begin acc_out = acc_in - 64'(ua * ub); lat = MC; end
`endif
            default: begin end
        endcase
    endfunction

    // Launch one op and measure how many cycles busy stays high, tracking
    // whether HI/LO moved during busy and whether active rose with start.
    task automatic apply_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int lat, output bit stable, output bit act_ok);
        logic [31:0] oh;
        logic [31:0] ol;
        @(negedge clk);
        oh = HI; ol = LO;
        start = 1'b1; MDUOp = op; A = a; B = b;
        #1 act_ok = (active === 1'b1);
        @(posedge clk); #1;
        start = 1'b0; MDUOp = 4'd0; A = 32'd0; B = 32'd0;
        lat = 0; stable = 1'b1;
        while (busy === 1'b1 && lat < 40) begin
            if (HI !== oh || LO !== ol) stable = 1'b0;
            lat++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        bit          st;
        bit          ao;
        logic [63:0] m_acc;
        logic [63:0] e_acc;
        int          e_lat;
        logic [3:0]  ops[12];

        reset = 1'b1; start = 1'b0; MDUOp = 4'd0; A = 32'd0; B = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi", 64'(HI), 64'd0);
        chk("reset_lo", 64'(LO), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_active", 64'(active), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", 64'(busy), 64'd0);

        add_vec("mult_neg",    4'd1, 32'hFFFFFFFE, 32'd3,        32'hAAAA, 32'hBBBB, 32'hFFFFFFFF, 32'hFFFFFFFA, MC);
        add_vec("multu_max",   4'd2, 32'hFFFFFFFF, 32'd2,        32'h0,    32'h0,    32'h00000001, 32'hFFFFFFFE, MC);
        add_vec("mult_min_sq", 4'd1, 32'h80000000, 32'h80000000, 32'h1,    32'h2,    32'h40000000, 32'h00000000, MC);
        add_vec("div_neg",     4'd3, 32'hFFFFFFF9, 32'd2,        32'h0,    32'h0,    32'hFFFFFFFF, 32'hFFFFFFFD, DC);
        add_vec("div_negdvsr", 4'd3, 32'd7,        32'hFFFFFFFE, 32'h0,    32'h0,    32'h00000001, 32'hFFFFFFFD, DC);
        add_vec("div_ovf",     4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h5,    32'h6,    32'h00000000, 32'h80000000, DC);
        add_vec("divu",        4'd4, 32'd100,      32'd7,        32'h0,    32'h0,    32'd2,        32'd14,       DC);
        add_vec("divu_by0",    4'd4, 32'd7,        32'd0,        32'h11,   32'h22,   32'h11,       32'h22,       DC);
        add_vec("div_by0",     4'd3, 32'hFFFFFFF9, 32'd0,        32'h33,   32'h44,   32'h33,       32'h44,       DC);
        add_vec("mthi",        4'd5, 32'h1234,     32'd0,        32'h55,   32'h66,   32'h1234,     32'h66,       0);
        add_vec("mtlo",        4'd6, 32'h5678,     32'd0,        32'h55,   32'h66,   32'h55,       32'h5678,     0);
        add_vec("none",        4'd0, 32'h9,        32'h9,        32'h55,   32'h66,   32'h55,       32'h66,       0);
        add_vec("bad_op",      4'd15, 32'h9,       32'h9,        32'h77,   32'h88,   32'h77,       32'h88,       0);
`ifdef MDU_MADD_EN
        add_vec("maddu",       4'd8, 32'd1,        32'd1,        32'h0,    32'hFFFFFFFF, 32'h1,        32'h0,        MC);
        add_vec("msub",        4'd9, 32'd1,        32'd1,        32'h0,    32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, MC);
        add_vec("madd",        4'd7, 32'hFFFFFFFF, 32'd2,        32'h0,    32'h5,        32'h0,        32'h3,        MC);
`else
        add_vec("maddu_off",   4'd8, 32'd1,        32'd1,        32'h0,    32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 0);
        add_vec("msub_off",    4'd9, 32'd1,        32'd1,        32'h0,    32'h0,        32'h0,        32'h0,        0);
        add_vec("madd_off",    4'd7, 32'hFFFFFFFF, 32'd2,        32'h0,    32'h5,        32'h0,        32'h5,        0);
`endif

        foreach (vecs[i]) begin
            apply_op(4'd5, vecs[i].pre_hi, 32'd0, lat, st, ao);
            apply_op(4'd6, vecs[i].pre_lo, 32'd0, lat, st, ao);
            apply_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, st, ao);
            chk({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].exp_lat));
            chk({vecs[i].name, "_hi"}, 64'(HI), 64'(vecs[i].exp_hi));
            chk({vecs[i].name, "_lo"}, 64'(LO), 64'(vecs[i].exp_lo));
            chk({vecs[i].name, "_stable"}, 64'(st), 64'd1);
            chk({vecs[i].name, "_active"}, 64'(ao), 64'd1);
        end

        // Reset during a divide: abort, HI/LO cleared, no late commit.
        apply_op(4'd5, 32'h11, 32'd0, lat, st, ao);
        apply_op(4'd6, 32'h22, 32'd0, lat, st, ao);
        @(negedge clk);
        start = 1'b1; MDUOp = 4'd3; A = 32'd100; B = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_mid_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_hi", 64'(HI), 64'd0);
        chk("rst_mid_lo", 64'(LO), 64'd0);
        reset = 1'b0;
        repeat (DC + 2) begin @(posedge clk); #1; end
        chk("rst_no_late_commit", {HI, LO}, 64'd0);
        chk("rst_no_late_busy", 64'(busy), 64'd0);

        // A start pulse while busy must be ignored.
        @(negedge clk);
        start = 1'b1; MDUOp = 4'd1; A = 32'd7; B = 32'hFFFFFFFD;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (busy === 1'b1 && lat < 40) begin
            if (lat == 2) begin
                start = 1'b1; MDUOp = 4'd3; A = 32'd100; B = 32'd3;
            end else begin
                start = 1'b0;
            end
            lat++;
            @(posedge clk); #1;
        end
        start = 1'b0; MDUOp = 4'd0;
        chk("midbusy_lat", 64'(lat), 64'(MC));
        chk("midbusy_result", {HI, LO}, 64'hFFFFFFFF_FFFFFFEB);
        @(posedge clk); #1;
        chk("midbusy_no_relaunch", 64'(busy), 64'd0);
        m_acc = 64'hFFFFFFFF_FFFFFFEB;

        // Randomized operations against the reference model.
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd13};
        for (int k = 0; k < 40; k++) begin
            logic [3:0]  op;
            logic [31:0] ra;
            logic [31:0] rb;
            int          sel;
            op  = ops[$urandom_range(0, 11)];
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            else if (sel == 2) rb = 32'(ra[3:0]) + 32'd1;
            model(op, ra, rb, m_acc, e_acc, e_lat);
            apply_op(op, ra, rb, lat, st, ao);
            chk($sformatf("rnd%0d_op%0d_lat", k, op), 64'(lat), 64'(e_lat));
            chk($sformatf("rnd%0d_op%0d_hilo", k, op), {HI, LO}, e_acc);
            chk($sformatf("rnd%0d_op%0d_stable", k, op), 64'(st), 64'd1);
            m_acc = e_acc;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multiply/divide unit in the E stage of the 5-stage pipeline.
- Responds to mult/div/move-to requests issued by the E-stage control decode.
- Provides HI/LO to the E-stage result mux for mfhi/mflo.
- Provides busy/active to the stall unit, so that any MDU instruction in D stalls while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high; sampled only on the rising edge of clk
- start  input  1  E-stage instruction is an MDU op that must launch this cycle; already qualified by E_REG bubble clear
- MDUOp  input  4  operation code, valid when start=1
- A  input  32  operand rs (forwarded FE_RD1)
- B  input  32  operand rt (forwarded FE_RD2)
- busy  output  1  operation in flight
- active  output  1  start | busy; drives the stall unit
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset values: HI=0, LO=0, busy=0, internal counter=0, shadow results=0.
- Reset mid-operation aborts the operation. HI/LO do not receive the pending result.
- MDUOp encoding:
  - 0 NONE
  - 1 MULT
  - 2 MULTU
  - 3 DIV
  - 4 DIVU
  - 5 MTHI
  - 6 MTLO
  - 7 MADD
  - 8 MADDU
  - 9 MSUB
  - 10 MSUBU
  - Any other code is treated as NONE.
- States: IDLE (busy=0) and RUN (busy=1).
- IDLE, start=1, MULT/MULTU/DIV/DIVU/madd family:
  - At the edge, compute the 64-bit result into shadow {sHI,sLO}.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
- IDLE, start=1, MTHI/MTLO: HI<=A or LO<=A at that edge; busy stays 0 (zero latency).
- RUN: counter decrements each edge. On the edge where counter==1, commit HI<=sHI, LO<=sLO, busy<=0, return to IDLE.
- Timing: start sampled at edge t.
  - busy=1 for exactly N cycles after edge t.
  - New HI/LO are visible from the same cycle busy falls.
  - mfhi/mflo in D therefore stalls until then.
- start while busy=1 is ignored. The stall unit guarantees this never happens; the bench checks it anyway.
- MULT: signed 32x32->64. MULTU: unsigned. HI = upper 32 bits, LO = lower 32 bits.
- DIV: signed, quotient truncated toward zero into LO; remainder (sign of dividend) into HI.
- DIV special case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient into LO, remainder into HI.
- Divide by zero (B=0): the operation still runs DIV_CYCLES with busy; HI/LO are left unchanged at commit.
- HI/LO change only at commit, MTHI/MTLO, or reset. They never show partial results.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - MADD: {HI,LO} += signed A*B.
  - MADDU: unsigned add.
  - MSUB: {HI,LO} -= signed A*B.
  - MSUBU: unsigned subtract.
  - Arithmetic is mod 2^64. The accumulator is the {HI,LO} value at the start edge.
  - Latency is MULT_CYCLES.
- Not defined: codes 7-10 are treated as NONE. No busy, no state change.

Decomposition:
- MDUOp codes (`MDUOp_NONE ... `MDUOp_MSUBU`) go in the shared const.v header beside the ALUOp/GRFWDSrc codes. CU decodes into them; the stall unit uses them.
- Default latency constants also live there.
- No sub-module: the flat unit is shadow regs, a counter and the HI/LO regs.

Test Plan:
- reset then idle -> HI=0, LO=0, busy=0, active=0.
- MULT A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA. HI/LO keep their old values during busy.
- MULTU A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- DIV A=-7, B=2 -> after 10 cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU A=7, B=0 with HI=0x11, LO=0x22 -> busy 10 cycles; HI/LO unchanged.
- DIV start, reset asserted at busy cycle 4 -> next cycle busy=0, HI=LO=0; no late commit.
- MTHI A=0x1234 -> HI=0x1234 next cycle, busy never rises.
- start pulsed again mid-busy -> ignored; result equals the first op.
- With MDU_MADD_EN, HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 -> HI=1, LO=0 after 5 cycles.
- Without MDU_MADD_EN, the same MADDU stimulus -> no busy, HI/LO unchanged.
